// File: rtl/am_envelope_detector_pkg.sv
// Shared definitions for the AM envelope detector slice: sample width,
// offset-binary zero code, the accumulator FSM states and small arithmetic
// helpers used by the rectifier and the optional DC-removal stage.
package am_demod_pkg;

    localparam int SAMPLE_W = 8;
    localparam logic [SAMPLE_W-1:0] ZERO_CODE = 8'h80;

    typedef enum logic {
        DISABLED = 1'b0,
        ACCUM    = 1'b1
    } accum_state_t;

    // Clamp a wide signed value into the signed 8-bit sample range.
    function automatic logic signed [SAMPLE_W-1:0] sat8(input logic signed [15:0] x);
        if (x > 16'sd127) begin
            return 8'sd127;
        end else if (x < -16'sd128) begin
            return -8'sd128;
        end else begin
            return $signed(x[SAMPLE_W-1:0]);
        end
    endfunction

    // Magnitude of a signed sample as unsigned; -128 maps to 128, which the
    // two's-complement negate produces naturally as 8'h80.
    function automatic logic [SAMPLE_W-1:0] rectify(input logic signed [SAMPLE_W-1:0] s);
        logic signed [SAMPLE_W-1:0] neg;
        neg = -s;
        return s[SAMPLE_W-1] ? $unsigned(neg) : $unsigned(s);
    endfunction

endpackage

// File: rtl/am_envelope_detector_if.sv
// Sample-in / envelope-out stream bundle for the AM envelope detector.
// The master side produces samples and consumes results; the detector is
// the slave.
interface am_envelope_detector_if;
    import am_demod_pkg::*;

    logic                in_valid;
    logic [SAMPLE_W-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [SAMPLE_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/am_envelope_detector_dc_blocker.sv
// DC-removal stage for the AM envelope detector. Tracks the running DC level
// of the centred sample as a signed 8.8 value with a 1/256 leaky integrator
// and subtracts its integer part from each sample, saturating to 8 bits.
// Only instantiated when AM_DC_BLOCK_EN is defined; adds one cycle of latency.
module am_dc_blocker
    import am_demod_pkg::*;
(
    input  logic                       main_clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic signed [SAMPLE_W-1:0] in_sample,
    output logic                       out_valid,
    output logic signed [SAMPLE_W-1:0] out_sample
);

    logic signed [15:0] dc;
    logic signed [16:0] dc_err;
    logic signed [16:0] dc_next;
    logic signed [15:0] corrected;

    // Error between the scaled sample and the DC estimate is computed one bit
    // wider so that the full-scale swing cannot wrap before the >>> 8.
    always_comb begin
        dc_err    = {in_sample[SAMPLE_W-1], in_sample, 8'h00} - {dc[15], dc};
        dc_next   = {dc[15], dc} + (dc_err >>> 8);
        corrected = {{8{in_sample[SAMPLE_W-1]}}, in_sample} - (dc >>> 8);
    end

    // DC estimate and corrected sample advance only on valid samples.
    always_ff @(posedge main_clk or negedge rst) begin
        if (!rst) begin
            dc         <= '0;
            out_valid  <= 1'b0;
            out_sample <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                dc         <= 16'(dc_next);
                out_sample <= sat8(corrected);
            end
        end
    end

endmodule

// File: rtl/am_envelope_detector.sv
// AM envelope detector: rectifies 8-bit offset-binary samples and
// boxcar-averages them over 2^DECIM_LOG2 samples, presenting one envelope
// magnitude per block through a single-entry valid/ready output register.
// A result that arrives while the register is full and stalled is dropped
// and flagged on the sticky overflow output.
// Optional feature macro: AM_DC_BLOCK_EN inserts am_dc_blocker ahead of the
// rectifier (one extra cycle of latency).
module am_envelope_detector
    import am_demod_pkg::*;
#(
    parameter int DECIM_LOG2 = 4
)
(
    input  logic                   main_clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   clear_ovf,
    output logic                   overflow,
    am_envelope_detector_if.slave  stream
);

    localparam int ACC_W = SAMPLE_W + DECIM_LOG2;
    localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;

    logic signed [SAMPLE_W-1:0] centered;
    logic                       rect_in_valid;
    logic signed [SAMPLE_W-1:0] rect_in;

    logic                       mag_valid;
    logic [SAMPLE_W-1:0]        mag;

    accum_state_t               state_q;
    accum_state_t               state_d;
    logic [ACC_W-1:0]           acc_q;
    logic [ACC_W-1:0]           acc_d;
    logic [ACC_W-1:0]           acc_sum;
    logic [DECIM_LOG2-1:0]      cnt_q;
    logic [DECIM_LOG2-1:0]      cnt_d;
    logic                       result_valid;
    logic [SAMPLE_W-1:0]        block_result;

    logic                       out_valid_q;
    logic [SAMPLE_W-1:0]        out_data_q;
    logic                       overflow_q;
    logic                       consume;
    logic                       drop;

    assign centered = $signed(stream.in_data ^ ZERO_CODE);

`ifdef AM_DC_BLOCK_EN
    am_dc_blocker u_dc_blocker (
        .main_clk   (main_clk),
        .rst        (rst),
        .in_valid   (stream.in_valid),
        .in_sample  (centered),
        .out_valid  (rect_in_valid),
        .out_sample (rect_in)
    );
`else
    assign rect_in_valid = stream.in_valid;
    assign rect_in       = centered;
`endif

    // Rectifier register: magnitude of the centred sample, tagged with valid.
    always_ff @(posedge main_clk or negedge rst) begin
        if (!rst) begin
            mag_valid <= 1'b0;
            mag       <= '0;
        end else begin
            mag_valid <= rect_in_valid;
            if (rect_in_valid) begin
                mag <= rectify(rect_in);
            end
        end
    end

    // Accumulator FSM state, running sum and in-block sample count.
    always_ff @(posedge main_clk or negedge rst) begin
        if (!rst) begin
            state_q <= DISABLED;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: accumulate while enabled, close a block on its last
    // sample, and throw away any partial block as soon as enable drops.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        result_valid = 1'b0;
        acc_sum      = acc_q + ACC_W'(mag);
        block_result = SAMPLE_W'(acc_sum >> DECIM_LOG2);

        case (state_q)
            DISABLED: begin
                acc_d = '0;
                cnt_d = '0;
                if (enable) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (!enable) begin
                    state_d = DISABLED;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (mag_valid) begin
                    if (cnt_q == CNT_LAST) begin
                        result_valid = 1'b1;
                        acc_d        = '0;
                        cnt_d        = '0;
                    end else begin
                        acc_d = acc_sum;
                        cnt_d = cnt_q + DECIM_LOG2'(1);
                    end
                end
            end
            default: begin
                state_d = DISABLED;
                acc_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    assign consume = out_valid_q && stream.out_ready;
    assign drop    = result_valid && out_valid_q && !stream.out_ready;

    // Single-entry output register; a stalled entry is never overwritten, and
    // a drop outranks a simultaneous clear of the sticky overflow flag.
    always_ff @(posedge main_clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (result_valid && (!out_valid_q || consume)) begin
                out_valid_q <= 1'b1;
                out_data_q  <= block_result;
            end else if (consume) begin
                out_valid_q <= 1'b0;
            end

            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clear_ovf) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign stream.out_valid = out_valid_q;
    assign stream.out_data  = out_data_q;
    assign overflow         = overflow_q;

endmodule
